// File: rtl/amstrad_scandoubler.sv
// 15 kHz -> 31 kHz line doubler: a two-bank line buffer captures one input line while the other bank is replayed twice.
// Optional macro SCANLINES_EN adds a 'scanlines' input that halves every gun on the second replay pass.
module amstrad_scandoubler #(
    parameter int LB_AW = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_16,
    input  logic       ce_32,
    input  logic [1:0] red_in,
    input  logic [1:0] green_in,
    input  logic [1:0] blue_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
`ifdef SCANLINES_EN
    input  logic       scanlines,
`endif
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       hblank,
    output logic       vblank,
    output logic       hsync,
    output logic       vsync
);

    typedef enum logic [1:0] {
        PASS0 = 2'd0,
        PASS1 = 2'd1,
        IDLE  = 2'd2
    } rd_state_t;

    localparam int              DEPTH   = 2 ** (LB_AW + 1);
    localparam logic [LB_AW-1:0] PTR_MAX = {LB_AW{1'b1}};
    localparam logic [LB_AW-1:0] PTR_ONE = {{(LB_AW-1){1'b0}}, 1'b1};
    localparam logic [LB_AW-1:0] PTR_ZERO = {LB_AW{1'b0}};

    function automatic logic [1:0] gun_out(input logic [1:0] v, input logic blank, input logic halve);
        if (blank) begin
            gun_out = 2'd0;
        end else if (halve) begin
            gun_out = {1'b0, v[1]};
        end else begin
            gun_out = v;
        end
    endfunction

    logic [6:0]       mem_r [0:DEPTH-1];
    logic             hs_prev_r, wbank_r, synced_r, vs_lat_r, vb_lat_r;
    logic [LB_AW-1:0] wptr_r, rptr_r, line_len_r;
    logic [7:0]       hs_cnt_r, hs_len_r;
    rd_state_t        state_r;

    logic [6:0]       s1_data_r;
    logic             s1_valid_r, s1_idle_r, s1_halve_r, s1_hs_r, s1_vs_r, s1_vb_r;

    logic             bnd_s, hs_hit_s, scan_s;
    logic [LB_AW:0]   waddr_s, raddr_s;
    logic [6:0]       wdata_s;
    logic [LB_AW-1:0] last_s;

`ifdef SCANLINES_EN
    assign scan_s = scanlines;
`else
    assign scan_s = 1'b0;
`endif

    // Boundary detect, buffer addressing and output hsync window.
    always_comb begin
        bnd_s    = ce_16 & hsync_in & ~hs_prev_r;
        raddr_s  = {~wbank_r, rptr_r};
        wdata_s  = {hblank_in, red_in, green_in, blue_in};
        last_s   = line_len_r - PTR_ONE;
        hs_hit_s = ({8'd0, rptr_r} < {{LB_AW{1'b0}}, 1'b0, hs_len_r[7:1]});
        if (bnd_s) begin
            // The boundary pixel lands in entry 0 of the freshly selected bank.
            waddr_s = {~wbank_r, PTR_ZERO};
        end else begin
            waddr_s = {wbank_r, wptr_r};
        end
    end

    // Line-buffer write port and registered read port.
    always_ff @(posedge clk) begin
        if (ce_16) begin
            mem_r[waddr_s] <= wdata_s;
        end
        if (ce_32) begin
            s1_data_r <= mem_r[raddr_s];
        end
    end

    // Write side: pointer, hsync width counter and per-line latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_r  <= 1'b0;
            wbank_r    <= 1'b0;
            synced_r   <= 1'b0;
            wptr_r     <= PTR_ZERO;
            line_len_r <= PTR_ZERO;
            hs_cnt_r   <= 8'd0;
            hs_len_r   <= 8'd0;
            vs_lat_r   <= 1'b0;
            vb_lat_r   <= 1'b0;
        end else if (ce_16) begin
            hs_prev_r <= hsync_in;
            if (bnd_s) begin
                // The partial line captured before the first boundary is never shown.
                line_len_r <= synced_r ? wptr_r : PTR_ZERO;
                synced_r   <= 1'b1;
                hs_len_r   <= hs_cnt_r;
                hs_cnt_r   <= 8'd1;
                wbank_r    <= ~wbank_r;
                wptr_r     <= PTR_ONE;
                vs_lat_r   <= vsync_in;
                vb_lat_r   <= vblank_in;
            end else begin
                if (wptr_r != PTR_MAX) begin
                    wptr_r <= wptr_r + PTR_ONE;
                end
                if (hsync_in && (hs_cnt_r != 8'd255)) begin
                    hs_cnt_r <= hs_cnt_r + 8'd1;
                end
            end
        end
    end

    // Read side: two passes over the stored line, then idle until the next boundary.
    always_ff @(posedge clk) begin
        if (reset || bnd_s) begin
            rptr_r  <= PTR_ZERO;
            state_r <= PASS0;
        end else if (ce_32 && (line_len_r != PTR_ZERO)) begin
            case (state_r)
                PASS0: begin
                    if (rptr_r == last_s) begin
                        rptr_r  <= PTR_ZERO;
                        state_r <= PASS1;
                    end else begin
                        rptr_r <= rptr_r + PTR_ONE;
                    end
                end
                PASS1: begin
                    if (rptr_r == last_s) begin
                        state_r <= IDLE;
                    end else begin
                        rptr_r <= rptr_r + PTR_ONE;
                    end
                end
                IDLE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // First pipeline stage: timing flags that travel alongside the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_idle_r  <= 1'b0;
            s1_halve_r <= 1'b0;
            s1_hs_r    <= 1'b0;
            s1_vs_r    <= 1'b0;
            s1_vb_r    <= 1'b1;
        end else if (ce_32) begin
            s1_valid_r <= (line_len_r != PTR_ZERO);
            s1_idle_r  <= (state_r == IDLE);
            s1_halve_r <= scan_s & (state_r == PASS1);
            s1_hs_r    <= hs_hit_s & (state_r != IDLE);
            s1_vs_r    <= vs_lat_r;
            s1_vb_r    <= vb_lat_r;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (reset || !s1_valid_r) begin
            red    <= 2'd0;
            green  <= 2'd0;
            blue   <= 2'd0;
            hblank <= 1'b1;
            vblank <= 1'b1;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end else if (s1_idle_r) begin
            red    <= 2'd0;
            green  <= 2'd0;
            blue   <= 2'd0;
            hblank <= 1'b1;
            vblank <= s1_vb_r;
            hsync  <= 1'b0;
            vsync  <= s1_vs_r;
        end else begin
            red    <= gun_out(s1_data_r[5:4], s1_data_r[6], s1_halve_r);
            green  <= gun_out(s1_data_r[3:2], s1_data_r[6], s1_halve_r);
            blue   <= gun_out(s1_data_r[1:0], s1_data_r[6], s1_halve_r);
            hblank <= s1_data_r[6];
            vblank <= s1_vb_r;
            hsync  <= s1_hs_r;
            vsync  <= s1_vs_r;
        end
    end

endmodule

// File: tb/tb_amstrad_scandoubler.sv
// Line-table bench for amstrad_scandoubler: each record describes one input line and the
// previous line's replay that must appear while it is being captured.
module tb_amstrad_scandoubler;

    logic       clk = 1'b0;
    logic       reset, ce_16, ce_32;
    logic [1:0] red_in, green_in, blue_in;
    logic       hblank_in, vblank_in, hsync_in, vsync_in;
    logic [1:0] red, green, blue;
    logic       hblank, vblank, hsync, vsync;
`ifdef SCANLINES_EN
    logic       scanlines;
`endif

    always #5 clk = ~clk;

    amstrad_scandoubler #(.LB_AW(10)) dut (
        .clk(clk), .reset(reset), .ce_16(ce_16), .ce_32(ce_32),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef SCANLINES_EN
        .scanlines(scanlines),
`endif
        .red(red), .green(green), .blue(blue),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
    );

    // Observed bundle: {hblank, vblank, hsync, vsync, r, g, b}
    logic [9:0] obs;
    assign obs = {hblank, vblank, hsync, vsync, red, green, blue};
    localparam logic [9:0] BLANK = 10'h300;

    typedef struct {
        int         len;      // ce_16 pixels in this input line
        int         hsw;      // hsync_in width in pixels
        logic [1:0] col;      // colour on all guns
        int         hbn;      // hblank_in over pixels 0..hbn-1
        logic       vs;
        logic       vb;
        int         exp_len;  // line length being replayed (previous line, clamped to 1023)
        int         exp_hsh;  // expected output hsync width in ce_32 (clamped previous hsw / 2)
        logic [1:0] exp_col;
        int         exp_hbn;
    } line_t;

    line_t tbl[11];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One ce_32 slot (two clk); returns the output that the read at this slot produced.
    task automatic slot(input logic c16, output logic [9:0] o);
        ce_32 = 1'b1;
        ce_16 = c16;
        @(posedge clk);
        @(negedge clk);
        ce_32 = 1'b0;
        ce_16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o = obs;
    endtask

    function automatic logic [9:0] exp_out(input line_t t, input int j);
        logic       hb, hs;
        logic [1:0] c;
        int         r;
        if (t.exp_len == 0) return BLANK;
        if (j >= 2 * t.exp_len) return {1'b1, t.vb, 1'b0, t.vs, 6'd0};
        r  = j % t.exp_len;
        hb = (r < t.exp_hbn);
        c  = hb ? 2'd0 : t.exp_col;
`ifdef SCANLINES_EN
        if (j >= t.exp_len) c = c >> 1;
`endif
        hs = (r < t.exp_hsh);
        return {hb, t.vb, hs, t.vs, c, c, c};
    endfunction

    task automatic drive_pixel(input line_t t, input int p);
        hsync_in  = (p < t.hsw);
        hblank_in = (p < t.hbn);
        red_in    = t.col;
        green_in  = t.col;
        blue_in   = t.col;
        vsync_in  = t.vs;
        vblank_in = t.vb;
    endtask

    // Drive one whole input line; compare pass0 / pass1 / idle regions of the replay.
    task automatic run_line(input int idx, output logic [9:0] s0);
        line_t      t;
        logic [9:0] o, e;
        bit         seen[3], badr[3];
        int         fs[3];
        logic [9:0] fa[3], fe[3];
        int         j, rg;
        string      rn[3];
        rn[0] = "pass0"; rn[1] = "pass1"; rn[2] = "idle";
        t = tbl[idx];
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0; badr[k] = 1'b0; fs[k] = 0; fa[k] = 10'd0; fe[k] = 10'd0;
        end
        s0 = 10'd0;
        for (int p = 0; p < t.len; p++) begin
            drive_pixel(t, p);
            for (int h = 0; h < 2; h++) begin
                slot(h == 0, o);
                if (p == 0 && h == 0) begin
                    s0 = o;
                end else begin
                    j  = 2 * p + h - 1;
                    e  = exp_out(t, j);
                    rg = (t.exp_len == 0) ? 0 : (j < t.exp_len) ? 0 : (j < 2 * t.exp_len) ? 1 : 2;
                    seen[rg] = 1'b1;
                    if (o !== e && !badr[rg]) begin
                        badr[rg] = 1'b1; fs[rg] = j; fa[rg] = o; fe[rg] = e;
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (seen[k]) begin
                total++;
                if (badr[k]) begin
                    bad++;
                    $display("FAIL line%0d_%s: at replay slot %0d got %h want %h", idx, rn[k], fs[k], fa[k], fe[k]);
                end
            end
        end
    endtask

    initial begin
        logic [9:0] s0;
        //            len   hsw  col   hbn  vs    vb    xlen  xhs  xcol  xhbn
        tbl[0]  = '{200,  16,  2'd1, 0,   1'b1, 1'b1, 0,    0,   2'd0, 0};
        tbl[1]  = '{200,  16,  2'd2, 20,  1'b0, 1'b1, 200,  8,   2'd1, 0};
        tbl[2]  = '{150,  10,  2'd3, 0,   1'b0, 1'b0, 200,  8,   2'd2, 20};
        tbl[3]  = '{300,  20,  2'd1, 40,  1'b0, 1'b0, 150,  5,   2'd3, 0};
        tbl[4]  = '{1024, 64,  2'd2, 128, 1'b0, 1'b0, 300,  10,  2'd1, 40};
        tbl[5]  = '{1500, 64,  2'd3, 0,   1'b1, 1'b1, 1023, 32,  2'd2, 128};
        tbl[6]  = '{100,  8,   2'd1, 0,   1'b0, 1'b1, 1023, 32,  2'd3, 0};
        tbl[7]  = '{400,  300, 2'd2, 0,   1'b0, 1'b0, 100,  4,   2'd1, 0};
        tbl[8]  = '{100,  6,   2'd3, 0,   1'b0, 1'b0, 400,  127, 2'd2, 0};
        // after a mid-line reset: first line is never shown, second shows the first
        tbl[9]  = '{100,  8,   2'd1, 0,   1'b1, 1'b0, 0,    0,   2'd0, 0};
        tbl[10] = '{100,  8,   2'd2, 0,   1'b0, 1'b0, 100,  4,   2'd1, 0};

        reset = 1'b1; ce_16 = 1'b0; ce_32 = 1'b0;
        red_in = 2'd0; green_in = 2'd0; blue_in = 2'd0;
        hblank_in = 1'b0; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
`ifdef SCANLINES_EN
        scanlines = 1'b1;
`endif
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_state", obs, BLANK);

        for (int i = 0; i <= 8; i++) begin
            run_line(i, s0);
            if (i == 0) check("first_edge_slot0", s0, BLANK);
        end

        // Reset in the middle of a line.
        for (int p = 0; p < 50; p++) begin
            drive_pixel(tbl[8], p);
            slot(1'b1, s0);
            slot(1'b0, s0);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midreset_state", obs, BLANK);

        run_line(9, s0);
        check("midreset_edge1_slot0", s0, BLANK);
        run_line(10, s0);
        check("midreset_edge2_slot0", s0, BLANK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
